// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage data-bus responder: access op/size encodings and FSM states.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package mem_access_pkg;

    localparam logic [1:0] ACCESS_OP_D2R = 2'd0;   // ALU result straight to register
    localparam logic [1:0] ACCESS_OP_M2R = 2'd1;   // load
    localparam logic [1:0] ACCESS_OP_R2M = 2'd2;   // store

    localparam logic [1:0] ACCESS_SZ_BYTE = 2'd0;
    localparam logic [1:0] ACCESS_SZ_HALF = 2'd1;
    localparam logic [1:0] ACCESS_SZ_WORD = 2'd2;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUS  = 1'b1;

    // Size 3 is treated like WORD so it can never produce a partial-lane access.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lo);
        if (sz == ACCESS_SZ_BYTE) return 1'b0;
        if (sz == ACCESS_SZ_HALF) return lo[0];
        return |lo;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: byte enables, store replication, load extract and sign/zero extension.
// Latency: purely combinational.
// Backpressure: none; also usable by the instruction-fetch side.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [1:0]  sz,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wr_data,
    input  logic [31:0] rd_data,
    input  logic        zero_ext,
    output logic [3:0]  byte_en,
    output logic [31:0] wr_rep,
    output logic [31:0] rd_ext,
    output logic        misaligned
);

    logic [31:0] rd_shifted;

    // Bring the addressed lane down to bit 0, then steer/extend by size.
    always_comb begin
        rd_shifted = rd_data >> {addr_lo, 3'b000};
        misaligned = is_misaligned(sz, addr_lo);
        case (sz)
            ACCESS_SZ_BYTE: begin
                byte_en = 4'b0001 << addr_lo;
                wr_rep  = {4{wr_data[7:0]}};
                rd_ext  = zero_ext ? {24'd0, rd_shifted[7:0]}
                                   : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            end
            ACCESS_SZ_HALF: begin
                byte_en = 4'b0011 << {addr_lo[1], 1'b0};
                wr_rep  = {2{wr_data[15:0]}};
                rd_ext  = zero_ext ? {16'd0, rd_shifted[15:0]}
                                   : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            end
            default: begin
                byte_en = 4'b1111;
                wr_rep  = wr_data;
                rd_ext  = rd_data;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM-stage responder: performs the EX request on the data bus and registers the result toward WB.
// Latency: D2R/misaligned 1 cycle; loads/stores 2 cycles minimum plus one per bus_stall cycle.
// Backpressure: stall_o holds upstream from the issue cycle until the bus completes. Optional LL/SC: MIPS_LLSC_EN.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic [1:0]        mem_access_op,
    input  logic [1:0]        mem_access_sz,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       data_i,
    input  logic [4:0]        reg_addr_i,
    input  logic              flag_unsigned,
    input  logic              is_ll,
    input  logic              is_sc,
    input  logic              llbit_clear,
    output logic              stall_o,
    output logic [31:0]       data_o,
    output logic [4:0]        reg_addr_o,
    output logic              addr_err,
    output logic [ADDR_W-1:0] bus_address,
    output logic [3:0]        bus_byte_enable,
    output logic              bus_read,
    output logic              bus_write,
    output logic [31:0]       bus_wrdata,
    input  logic [31:0]       bus_rddata,
    input  logic              bus_stall
);

    logic [0:0]        state;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wrdata_q;
    logic              rd_q;
    logic              wr_q;
    logic [1:0]        sz_q;
    logic [1:0]        lo_q;
    logic              uns_q;
    logic              sc_q;
    logic [4:0]        reg_q;

    logic              in_bus;
    logic              is_mem;
    logic              sc_fail;
    logic              issue;
    logic              done;

    logic [1:0]        la_sz;
    logic [1:0]        la_lo;
    logic              la_uns;
    logic [3:0]        la_be;
    logic [31:0]       la_wr;
    logic [31:0]       la_rd;
    logic              la_mis;

`ifdef MIPS_LLSC_EN
    logic              llbit;
    logic              ll_q;
`else
    logic              unused_llsc;
    assign unused_llsc = is_ll ^ llbit_clear;
`endif

    assign in_bus = (state == ST_BUS);
    assign done   = in_bus && !bus_stall;
    assign is_mem = (mem_access_op == ACCESS_OP_M2R) || (mem_access_op == ACCESS_OP_R2M);

`ifdef MIPS_LLSC_EN
    assign sc_fail = is_sc && (mem_access_op == ACCESS_OP_R2M) && !llbit;
`else
    assign sc_fail = 1'b0;
`endif

    // A bus access starts only from IDLE for an aligned load/store that is allowed to proceed.
    assign issue = !rst && !in_bus && req_valid && is_mem && !la_mis && !sc_fail;

    // While in BUS the lane logic must see the captured request, not the (held) live inputs.
    assign la_sz  = in_bus ? sz_q  : mem_access_sz;
    assign la_lo  = in_bus ? lo_q  : mem_addr[1:0];
    assign la_uns = in_bus ? uns_q : flag_unsigned;

    mem_lane_align u_lane (
        .sz         (la_sz),
        .addr_lo    (la_lo),
        .wr_data    (data_i),
        .rd_data    (bus_rddata),
        .zero_ext   (la_uns),
        .byte_en    (la_be),
        .wr_rep     (la_wr),
        .rd_ext     (la_rd),
        .misaligned (la_mis)
    );

    // Bus is driven live on the issue cycle, then from the captured copies until completion.
    always_comb begin
        bus_address     = '0;
        bus_byte_enable = 4'd0;
        bus_wrdata      = 32'd0;
        bus_read        = 1'b0;
        bus_write       = 1'b0;
        if (issue) begin
            bus_address     = {mem_addr[ADDR_W-1:2], 2'b00};
            bus_byte_enable = la_be;
            bus_wrdata      = la_wr;
            bus_read        = (mem_access_op == ACCESS_OP_M2R);
            bus_write       = (mem_access_op == ACCESS_OP_R2M);
        end else if (in_bus) begin
            bus_address     = addr_q;
            bus_byte_enable = be_q;
            bus_wrdata      = wrdata_q;
            bus_read        = rd_q;
            bus_write       = wr_q;
        end
    end

    assign stall_o = issue || (in_bus && bus_stall);

    // Request FSM, captured bus copies and WB result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            addr_q     <= '0;
            be_q       <= 4'd0;
            wrdata_q   <= 32'd0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            sz_q       <= 2'd0;
            lo_q       <= 2'd0;
            uns_q      <= 1'b0;
            sc_q       <= 1'b0;
            reg_q      <= 5'd0;
            data_o     <= 32'd0;
            reg_addr_o <= 5'd0;
            addr_err   <= 1'b0;
        end else begin
            addr_err <= 1'b0;
            if (!in_bus) begin
                data_o     <= 32'd0;
                reg_addr_o <= 5'd0;
                if (req_valid) begin
                    if (!is_mem) begin
                        data_o     <= data_i;
                        reg_addr_o <= reg_addr_i;
                    end else if (la_mis) begin
                        addr_err <= 1'b1;
                    end else if (sc_fail) begin
                        reg_addr_o <= reg_addr_i;
                    end else begin
                        state    <= ST_BUS;
                        addr_q   <= {mem_addr[ADDR_W-1:2], 2'b00};
                        be_q     <= la_be;
                        wrdata_q <= la_wr;
                        rd_q     <= (mem_access_op == ACCESS_OP_M2R);
                        wr_q     <= (mem_access_op == ACCESS_OP_R2M);
                        sz_q     <= mem_access_sz;
                        lo_q     <= mem_addr[1:0];
                        uns_q    <= flag_unsigned;
                        sc_q     <= is_sc && (mem_access_op == ACCESS_OP_R2M);
                        reg_q    <= reg_addr_i;
                    end
                end
            end else if (done) begin
                state <= ST_IDLE;
                if (rd_q) begin
                    data_o     <= la_rd;
                    reg_addr_o <= reg_q;
                end else if (sc_q) begin
                    data_o     <= 32'd1;
                    reg_addr_o <= reg_q;
                end
            end
        end
    end

`ifdef MIPS_LLSC_EN
    // Link bit: set by LL completion, cleared by SC completion; an explicit clear always wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            llbit <= 1'b0;
            ll_q  <= 1'b0;
        end else begin
            if (issue) ll_q <= is_ll && (mem_access_op == ACCESS_OP_M2R);
            if (llbit_clear)        llbit <= 1'b0;
            else if (done && ll_q)  llbit <= 1'b1;
            else if (done && sc_q)  llbit <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mem_access.sv
// Randomized and directed checks of mem_access against a byte-level memory model.
// Latency: n/a.
// Backpressure: the bench acts as a bus slave with programmable wait states.
module tb_mem_access;

`ifdef MIPS_LLSC_EN
    localparam bit LLSC = 1'b1;
`else
    localparam bit LLSC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [1:0]  mem_access_op = 2'd0;
    logic [1:0]  mem_access_sz = 2'd0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] data_i = 32'd0;
    logic [4:0]  reg_addr_i = 5'd0;
    logic        flag_unsigned = 1'b0;
    logic        is_ll = 1'b0;
    logic        is_sc = 1'b0;
    logic        llbit_clear = 1'b0;
    logic        stall_o;
    logic [31:0] data_o;
    logic [4:0]  reg_addr_o;
    logic        addr_err;
    logic [31:0] bus_address;
    logic [3:0]  bus_byte_enable;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_wrdata;
    logic [31:0] bus_rddata = 32'd0;
    logic        bus_stall = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  mmem [int];   // reference memory, byte addressed
    logic [31:0] smem [int];   // slave memory, word addressed, written only by DUT strobes
    bit          model_llbit = 1'b0;

    always #5 clk = ~clk;

    mem_access #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .mem_access_op(mem_access_op),
        .mem_access_sz(mem_access_sz), .mem_addr(mem_addr), .data_i(data_i),
        .reg_addr_i(reg_addr_i), .flag_unsigned(flag_unsigned), .is_ll(is_ll), .is_sc(is_sc),
        .llbit_clear(llbit_clear), .stall_o(stall_o), .data_o(data_o), .reg_addr_o(reg_addr_o),
        .addr_err(addr_err), .bus_address(bus_address), .bus_byte_enable(bus_byte_enable),
        .bus_read(bus_read), .bus_write(bus_write), .bus_wrdata(bus_wrdata),
        .bus_rddata(bus_rddata), .bus_stall(bus_stall)
    );

    function automatic logic [7:0] mbyte(input int a);
        return mmem.exists(a) ? mmem[a] : 8'd0;
    endfunction

    task automatic preload(input int waddr, input logic [31:0] w);
        smem[waddr] = w;
        for (int i = 0; i < 4; i++) mmem[waddr + i] = w[8*i +: 8];
    endtask

    // Issues one request (entered at posedge+1) and acts as the bus slave until it retires.
    task automatic run_req(input logic [1:0] op, input logic [1:0] sz, input logic [31:0] addr,
                           input logic [31:0] data, input logic [4:0] rd, input logic uns,
                           input logic ll, input logic sc, input logic clr, input int nstall,
                           input string tag, output logic [31:0] obs_data,
                           output logic [4:0] obs_reg, output logic obs_err,
                           output int obs_wr, output int obs_stall);
        bit          is_mem, mis, sc_fail, go, chk_data;
        int          nb, beint, k;
        logic [3:0]  exp_be;
        logic [31:0] exp_wr, exp_ld, mask, exp_data, w;
        logic [4:0]  exp_reg;

        nb      = 1 << sz;
        is_mem  = (op == 2'd1) || (op == 2'd2);
        mis     = is_mem && ((addr % nb) != 0);
        sc_fail = LLSC && (op == 2'd2) && sc && !model_llbit;
        go      = is_mem && !mis && !sc_fail;
        beint   = ((1 << nb) - 1) << (addr % 4);
        exp_be  = beint[3:0];
        for (int i = 0; i < 4; i++) exp_wr[8*i +: 8] = data[8*(i % nb) +: 8];
        exp_ld = 32'd0;
        for (int i = 0; i < nb; i++) exp_ld = exp_ld | (32'(mbyte(int'(addr) + i)) << (8*i));
        mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
        if (!uns && nb < 4 && exp_ld[8*nb-1]) exp_ld = exp_ld | ~mask;

        chk_data = 1'b1;
        exp_data = 32'd0;
        exp_reg  = 5'd0;
        if (!is_mem) begin exp_data = data; exp_reg = rd; end
        else if (mis) chk_data = 1'b0;
        else if (sc_fail) exp_reg = rd;
        else if (op == 2'd1) begin exp_data = exp_ld; exp_reg = rd; end
        else if (sc) begin exp_data = 32'd1; exp_reg = rd; end
        else chk_data = 1'b0;

        req_valid = 1'b1; mem_access_op = op; mem_access_sz = sz; mem_addr = addr;
        data_i = data; reg_addr_i = rd; flag_unsigned = uns; is_ll = ll; is_sc = sc;
        llbit_clear = clr;
        obs_wr = 0; obs_stall = 0;
        for (k = 0; k < 64; k++) begin
            bus_stall = (k == 0) ? 1'b1 : (k <= nstall);   // high in IDLE must be ignored
            @(negedge clk);
            if (bus_read) bus_rddata = smem.exists(int'(bus_address)) ? smem[int'(bus_address)] : 32'd0;
            n_tests++;
            if (stall_o !== (go && (k == 0 || k <= nstall))) begin
                n_fail++;
                $display("FAIL %s stall_o k=%0d got %b exp %b", tag, k, stall_o, go && (k == 0 || k <= nstall));
            end
            n_tests++;
            if ({bus_read, bus_write} !== (go ? {op == 2'd1, op == 2'd2} : 2'b00)) begin
                n_fail++;
                $display("FAIL %s strobes k=%0d got %b%b go=%0d op=%0d", tag, k, bus_read, bus_write, go, op);
            end
            if (go) begin
                n_tests++;
                if ({bus_address, bus_byte_enable} !== {addr & ~32'd3, exp_be}) begin
                    n_fail++;
                    $display("FAIL %s addr/be k=%0d got %h/%b exp %h/%b", tag, k, bus_address, bus_byte_enable, addr & ~32'd3, exp_be);
                end
                if (op == 2'd2) begin
                    n_tests++;
                    if (bus_wrdata !== exp_wr) begin
                        n_fail++;
                        $display("FAIL %s wrdata k=%0d got %h exp %h", tag, k, bus_wrdata, exp_wr);
                    end
                end
            end
            if (stall_o) obs_stall++;
            if (bus_write && !stall_o) begin
                w = smem.exists(int'(bus_address)) ? smem[int'(bus_address)] : 32'd0;
                for (int i = 0; i < 4; i++) if (bus_byte_enable[i]) w[8*i +: 8] = bus_wrdata[8*i +: 8];
                smem[int'(bus_address)] = w;
                obs_wr++;
            end
            if (!stall_o) break;
            @(posedge clk); #1;
        end
        if (k == 64) begin
            n_tests++; n_fail++;
            $display("FAIL %s timeout stall_o stuck at %b", tag, stall_o);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; llbit_clear = 1'b0; is_ll = 1'b0; is_sc = 1'b0; bus_stall = 1'b0;
        @(negedge clk);
        obs_data = data_o; obs_reg = reg_addr_o; obs_err = addr_err;
        n_tests++;
        if (reg_addr_o !== exp_reg) begin
            n_fail++;
            $display("FAIL %s reg_addr_o got %0d exp %0d", tag, reg_addr_o, exp_reg);
        end
        if (chk_data) begin
            n_tests++;
            if (data_o !== exp_data) begin
                n_fail++;
                $display("FAIL %s data_o got %h exp %h", tag, data_o, exp_data);
            end
        end
        n_tests++;
        if (addr_err !== mis || obs_stall != (go ? 1 + nstall : 0) || obs_wr != int'(go && op == 2'd2)) begin
            n_fail++;
            $display("FAIL %s err/stalls/writes got %b/%0d/%0d exp %b/%0d/%0d", tag, addr_err, obs_stall, obs_wr,
                     mis, go ? 1 + nstall : 0, int'(go && op == 2'd2));
        end
        if (go && op == 2'd2)
            for (int i = 0; i < 4; i++) if (exp_be[i]) mmem[int'(addr & ~32'd3) + i] = exp_wr[8*i +: 8];
        if (clr) model_llbit = 1'b0;
        else if (go && op == 2'd1 && ll) model_llbit = 1'b1;
        else if (go && op == 2'd2 && sc) model_llbit = 1'b0;
        @(posedge clk); #1;
        if (mis) begin
            n_tests++;
            if (addr_err !== 1'b0) begin
                n_fail++;
                $display("FAIL %s addr_err pulse longer than one cycle got %b exp 0", tag, addr_err);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({stall_o, data_o, reg_addr_o, addr_err, bus_address, bus_byte_enable, bus_read, bus_write, bus_wrdata} !== '0) begin
            n_fail++;
            $display("FAIL reset outputs got stall=%b data=%h reg=%0d err=%b addr=%h be=%b rd=%b wr=%b", stall_o, data_o,
                     reg_addr_o, addr_err, bus_address, bus_byte_enable, bus_read, bus_write);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_d2r();
        logic [31:0] d; logic [4:0] r; logic e; int nw, ns;
        run_req(2'd0, 2'd2, 32'h55, 32'hDEADBEEF, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2, "d2r", d, r, e, nw, ns);
        n_tests++;
        if (d !== 32'hDEADBEEF || r !== 5'd5 || ns != 0) begin
            n_fail++;
            $display("FAIL d2r got data=%h reg=%0d stalls=%0d exp DEADBEEF/5/0", d, r, ns);
        end
        run_req(2'd3, 2'd1, 32'h3, 32'h0BADF00D, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 0, "invalid_op", d, r, e, nw, ns);
    endtask

    task automatic test_load_ext();
        logic [31:0] d; logic [4:0] r; logic e; int nw, ns;
        preload(32'h1000, 32'h80A1B2C3);
        run_req(2'd1, 2'd0, 32'h1003, 32'h0, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 0, "lb_signed", d, r, e, nw, ns);
        n_tests++;
        if (d !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_signed data got %h exp FFFFFF80", d); end
        run_req(2'd1, 2'd0, 32'h1003, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1, "lbu", d, r, e, nw, ns);
        n_tests++;
        if (d !== 32'h00000080) begin n_fail++; $display("FAIL lbu data got %h exp 00000080", d); end
        run_req(2'd1, 2'd1, 32'h1000, 32'h0, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0, 0, "lh_low", d, r, e, nw, ns);
        n_tests++;
        if (d !== 32'hFFFFB2C3) begin n_fail++; $display("FAIL lh_low data got %h exp FFFFB2C3", d); end
    endtask

    task automatic test_store_stall();
        logic [31:0] d; logic [4:0] r; logic e; int nw, ns;
        run_req(2'd2, 2'd1, 32'h2002, 32'h1234ABCD, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 3, "sh_stall", d, r, e, nw, ns);
        n_tests++;
        if (ns != 4 || nw != 1 || r !== 5'd0) begin
            n_fail++;
            $display("FAIL sh_stall got stalls=%0d writes=%0d reg=%0d exp 4/1/0", ns, nw, r);
        end
        run_req(2'd1, 2'd2, 32'h2000, 32'h0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 0, "sh_readback", d, r, e, nw, ns);
        n_tests++;
        if (d !== 32'hABCD0000) begin n_fail++; $display("FAIL sh_readback data got %h exp ABCD0000", d); end
    endtask

    task automatic test_misalign();
        logic [31:0] d; logic [4:0] r; logic e; int nw, ns;
        run_req(2'd1, 2'd2, 32'h3001, 32'h0, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 2, "lw_misaligned", d, r, e, nw, ns);
        n_tests++;
        if (e !== 1'b1 || r !== 5'd0 || ns != 0) begin
            n_fail++;
            $display("FAIL lw_misaligned got err=%b reg=%0d stalls=%0d exp 1/0/0", e, r, ns);
        end
        run_req(2'd2, 2'd1, 32'h3003, 32'h1, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 0, "sh_misaligned", d, r, e, nw, ns);
    endtask

    task automatic test_llsc();
        logic [31:0] d; logic [4:0] r; logic e; int nw, ns;
        run_req(2'd1, 2'd2, 32'h40, 32'h0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1, "ll_first", d, r, e, nw, ns);
        llbit_clear = 1'b1; @(posedge clk); #1; llbit_clear = 1'b0; model_llbit = 1'b0;
        run_req(2'd2, 2'd2, 32'h40, 32'hCAFE0001, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1, "sc_after_clear", d, r, e, nw, ns);
        n_tests++;
        if (d !== (LLSC ? 32'd0 : 32'd1) || nw != (LLSC ? 0 : 1) || r !== 5'd7) begin
            n_fail++;
            $display("FAIL sc_after_clear got data=%h writes=%0d reg=%0d exp %0d/%0d/7", d, nw, r, !LLSC, !LLSC);
        end
        run_req(2'd1, 2'd2, 32'h40, 32'h0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0, 0, "ll_second", d, r, e, nw, ns);
        run_req(2'd2, 2'd2, 32'h40, 32'hCAFE0002, 5'd7, 1'b0, 1'b0, 1'b1, 1'b0, 2, "sc_linked", d, r, e, nw, ns);
        n_tests++;
        if (d !== 32'd1 || nw != 1) begin
            n_fail++;
            $display("FAIL sc_linked got data=%h writes=%0d exp 1/1", d, nw);
        end
    endtask

    task automatic test_reset_in_bus();
        req_valid = 1'b1; mem_access_op = 2'd2; mem_access_sz = 2'd2; mem_addr = 32'h180;
        data_i = 32'h13579BDF; reg_addr_i = 5'd3; is_sc = 1'b1; bus_stall = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if (stall_o !== 1'b1 || bus_write !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_bus precondition got stall=%b write=%b exp 1/1", stall_o, bus_write);
        end
        rst = 1'b1; req_valid = 1'b0; is_sc = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; model_llbit = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({bus_read, bus_write, stall_o, reg_addr_o} !== '0) begin
            n_fail++;
            $display("FAIL rst_bus after reset got rd=%b wr=%b stall=%b reg=%0d exp all 0", bus_read, bus_write, stall_o, reg_addr_o);
        end
        bus_stall = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_tests++;
        if ({bus_write, reg_addr_o, data_o} !== '0) begin
            n_fail++;
            $display("FAIL rst_bus discarded completion got wr=%b reg=%0d data=%h exp 0", bus_write, reg_addr_o, data_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] d; logic [4:0] r; logic e; int nw, ns, sel;
        logic [1:0] op;
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 9);
            op  = (sel < 2) ? 2'd0 : (sel == 2) ? 2'd3 : (sel < 6) ? 2'd1 : 2'd2;
            run_req(op, 2'($urandom_range(0, 2)), 32'h100 + $urandom_range(0, 31), $urandom,
                    5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                    op == 2'd1 && $urandom_range(0, 2) == 0, op == 2'd2 && $urandom_range(0, 2) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 3), "random", d, r, e, nw, ns);
        end
    endtask

    initial begin
        test_reset();
        test_d2r();
        test_load_ext();
        test_store_stall();
        test_misalign();
        test_llsc();
        test_reset_in_bus();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
